// File: rtl/tick_stopwatch.sv
// BCD mm:ss stopwatch driven by rising edges of a slow, asynchronous tick level.
// The tick is synchronised and edge-detected in the i_clk domain, then prescaled to seconds.
module tick_stopwatch #(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 1,
    parameter int PRESC_W       = 32
) (
    input  logic               i_clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_start_stop,
    input  logic               i_clear,
    output logic [3:0]         o_sec_ones,
    output logic [3:0]         o_sec_tens,
    output logic [3:0]         o_min_ones,
    output logic [3:0]         o_min_tens,
    output logic               o_running,
    output logic               o_wrap,
    output logic [1:0]         dbg_state,
    output logic [PRESC_W-1:0] dbg_presc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    // Handshake: i_start_stop and i_clear are single-cycle strobes sampled on every
    // rising i_clk edge; there is no ready/backpressure, every strobe is acted on.

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick_pulse_q;
    logic                   sync_out;

    state_t                 state_q, state_d;
    logic [PRESC_W-1:0]     presc_q, presc_d;
    logic [3:0]             sec_ones_q, sec_ones_d;
    logic [3:0]             sec_tens_q, sec_tens_d;
    logic [3:0]             min_ones_q, min_ones_d;
    logic [3:0]             min_tens_q, min_tens_d;
    logic                   running_q;
    logic                   wrap_q, wrap_d;
    logic                   count_en;
    logic                   sec_step;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Edge detection runs in every state so edges seen while idle or paused are dropped.
    // The pulse is registered, putting the count one edge after the pulse cycle.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            hist_q       <= 1'b0;
            tick_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], i_tick};
            hist_q       <= sync_out;
            tick_pulse_q <= sync_out & ~hist_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start_stop) state_d = RUN;
            RUN:     if (i_start_stop) state_d = PAUSE;
            PAUSE:   if (i_start_stop) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (i_clear) state_d = IDLE;
    end

    // The count is governed by the current state, so a stop strobe still lets its tick land.
    assign count_en = (state_q == RUN) && tick_pulse_q && !i_clear;
    assign sec_step = count_en && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        if (i_clear) begin
            presc_d = '0;
        end else if (count_en) begin
            if (presc_q == PRESC_LAST) presc_d = '0;
            else                       presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (i_clear) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            min_ones_d = 4'd0;
            min_tens_d = 4'd0;
        end else if (sec_step) begin
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    if (min_ones_q != 4'd9) begin
                        min_ones_d = min_ones_q + 4'd1;
                    end else begin
                        min_ones_d = 4'd0;
                        if (min_tens_q != 4'd5) begin
                            min_tens_d = min_tens_q + 4'd1;
                        end else begin
                            min_tens_d = 4'd0;
                            wrap_d     = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
            running_q  <= (state_d == RUN);
            wrap_q     <= wrap_d;
        end
    end

    assign o_sec_ones = sec_ones_q;
    assign o_sec_tens = sec_tens_q;
    assign o_min_ones = min_ones_q;
    assign o_min_tens = min_tens_q;
    assign o_running  = running_q;
    assign o_wrap     = wrap_q;
    assign dbg_state  = state_q;
    assign dbg_presc  = presc_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: two instances (1 and 4 ticks per second) checked every cycle
// against an elapsed-seconds model, plus literal expectations at key points.
module tb_tick_stopwatch;

    localparam int S0 = 2;
    localparam int T0 = 1;
    localparam int S1 = 3;
    localparam int T1 = 4;

    logic       i_clk;
    logic       rst_n;
    logic [1:0] tick;
    logic [1:0] ss;
    logic [1:0] clr;
    logic [3:0] so [2];
    logic [3:0] st [2];
    logic [3:0] mo [2];
    logic [3:0] mt [2];
    logic [1:0] run;
    logic [1:0] wr;
    logic [1:0] dst [2];
    logic [31:0] presc0;
    logic [7:0]  presc1;

    int n_checks = 0;
    int n_fail   = 0;

    tick_stopwatch #(.SYNC_STAGES(S0), .TICKS_PER_SEC(T0), .PRESC_W(32)) u_dut0 (
        .i_clk(i_clk), .rst_n(rst_n), .i_tick(tick[0]), .i_start_stop(ss[0]), .i_clear(clr[0]),
        .o_sec_ones(so[0]), .o_sec_tens(st[0]), .o_min_ones(mo[0]), .o_min_tens(mt[0]),
        .o_running(run[0]), .o_wrap(wr[0]), .dbg_state(dst[0]), .dbg_presc(presc0)
    );

    tick_stopwatch #(.SYNC_STAGES(S1), .TICKS_PER_SEC(T1), .PRESC_W(8)) u_dut1 (
        .i_clk(i_clk), .rst_n(rst_n), .i_tick(tick[1]), .i_start_stop(ss[1]), .i_clear(clr[1]),
        .o_sec_ones(so[1]), .o_sec_tens(st[1]), .o_min_ones(mo[1]), .o_min_tens(mt[1]),
        .o_running(run[1]), .o_wrap(wr[1]), .dbg_state(dst[1]), .dbg_presc(presc1)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Model: elapsed seconds as an integer, prescale count, run mode (0 idle, 1 run, 2 pause),
    // and the sampled tick history (samp[k][j] = i_tick sampled j+1 edges ago).
    int m_secs  [2];
    int m_presc [2];
    int m_state [2];
    bit m_wrap  [2];
    bit samp    [2][8];

    function automatic int sync_of(input int k);
        return (k == 0) ? S0 : S1;
    endfunction

    function automatic int tps_of(input int k);
        return (k == 0) ? T0 : T1;
    endfunction

    always @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_secs[k]  <= 0;
                m_presc[k] <= 0;
                m_state[k] <= 0;
                m_wrap[k]  <= 1'b0;
                for (int j = 0; j < 8; j++) samp[k][j] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int s, p, md;
                bit w, pulse;
                pulse = samp[k][sync_of(k)] & ~samp[k][sync_of(k) + 1];
                s  = m_secs[k];
                p  = m_presc[k];
                md = m_state[k];
                w  = 1'b0;
                if (clr[k]) begin
                    s  = 0;
                    p  = 0;
                    md = 0;
                end else begin
                    if (md == 1 && pulse) begin
                        if (p == tps_of(k) - 1) begin
                            p = 0;
                            s = s + 1;
                            if (s == 3600) begin
                                s = 0;
                                w = 1'b1;
                            end
                        end else begin
                            p = p + 1;
                        end
                    end
                    if (ss[k]) md = (md == 1) ? 2 : 1;
                end
                m_secs[k]  <= s;
                m_presc[k] <= p;
                m_state[k] <= md;
                m_wrap[k]  <= w;
                for (int j = 7; j > 0; j--) samp[k][j] <= samp[k][j-1];
                samp[k][0] <= tick[k];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle out of reset
    always @(negedge i_clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d sec_ones", k), int'(so[k]), m_secs[k] % 10);
                chk($sformatf("u%0d sec_tens", k), int'(st[k]), (m_secs[k] / 10) % 6);
                chk($sformatf("u%0d min_ones", k), int'(mo[k]), (m_secs[k] / 60) % 10);
                chk($sformatf("u%0d min_tens", k), int'(mt[k]), m_secs[k] / 600);
                chk($sformatf("u%0d running", k), int'(run[k]), (m_state[k] == 1) ? 1 : 0);
                chk($sformatf("u%0d wrap", k), int'(wr[k]), int'(m_wrap[k]));
                chk($sformatf("u%0d state", k), int'(dst[k]), m_state[k]);
            end
            chk("u0 presc", int'(presc0), m_presc[0]);
            chk("u1 presc", int'(presc1), m_presc[1]);
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int k, input int n);
        repeat (n) begin
            tick[k] = 1'b1;
            cyc(2);
            tick[k] = 1'b0;
            cyc(2);
        end
        cyc(6);
    endtask

    task automatic press(input int k);
        ss[k] = 1'b1;
        cyc(1);
        ss[k] = 1'b0;
    endtask

    task automatic clear(input int k);
        clr[k] = 1'b1;
        cyc(1);
        clr[k] = 1'b0;
    endtask

    task automatic lit_time(input string name, input int k, input int mm, input int ss_v);
        chk({name, " min_tens"}, int'(mt[k]), mm / 10);
        chk({name, " min_ones"}, int'(mo[k]), mm % 10);
        chk({name, " sec_tens"}, int'(st[k]), ss_v / 10);
        chk({name, " sec_ones"}, int'(so[k]), ss_v % 10);
    endtask

    initial begin
        int wc;
        rst_n = 1'b0;
        tick  = 2'b00;
        ss    = 2'b00;
        clr   = 2'b00;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        lit_time("reset u0", 0, 0, 0);
        lit_time("reset u1", 1, 0, 0);
        chk("reset running", int'(run), 0);
        chk("reset wrap", int'(wr), 0);

        // start, then first-increment latency: sampled high at edge N, visible after N+3
        press(0);
        tick[0] = 1'b1;
        cyc(3);
        chk("latency before", int'(so[0]), 0);
        tick[0] = 1'b0;
        cyc(1);
        chk("latency at", int'(so[0]), 1);
        cyc(4);
        ticks(0, 4);
        lit_time("five ticks", 0, 0, 5);
        chk("five ticks running", int'(run[0]), 1);

        // seconds-to-minutes carry, then the full wrap
        clear(0);
        press(0);
        ticks(0, 59);
        lit_time("preload 59", 0, 0, 59);
        ticks(0, 1);
        lit_time("carry 01:00", 0, 1, 0);
        ticks(0, 3539);
        lit_time("at 59:59", 0, 59, 59);
        tick[0] = 1'b1;
        cyc(2);
        tick[0] = 1'b0;
        wc = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (wr[0]) wc++;
        end
        cyc(1);
        chk("wrap width", wc, 1);
        lit_time("after wrap", 0, 0, 0);
        chk("after wrap running", int'(run[0]), 1);

        // pause drops edges
        clear(0);
        press(0);
        ticks(0, 3);
        press(0);
        ticks(0, 4);
        lit_time("paused", 0, 0, 3);
        press(0);
        ticks(0, 1);
        lit_time("resume", 0, 0, 4);

        // clear coincident with the counted pulse at 00:09
        clear(0);
        press(0);
        ticks(0, 9);
        tick[0] = 1'b1;
        cyc(S0 + 1);
        clr[0] = 1'b1;
        cyc(1);
        clr[0]  = 1'b0;
        tick[0] = 1'b0;
        lit_time("clear+tick", 0, 0, 0);
        chk("clear+tick running", int'(run[0]), 0);
        chk("clear+tick wrap", int'(wr[0]), 0);
        chk("clear+tick state", int'(dst[0]), 0);
        cyc(6);

        // stop coincident with the counted pulse at 00:09
        press(0);
        ticks(0, 9);
        tick[0] = 1'b1;
        cyc(S0 + 1);
        ss[0] = 1'b1;
        cyc(1);
        ss[0]   = 1'b0;
        tick[0] = 1'b0;
        lit_time("stop+tick", 0, 0, 10);
        chk("stop+tick running", int'(run[0]), 0);
        chk("stop+tick state", int'(dst[0]), 2);
        cyc(6);

        // asynchronous reset at 12:34
        clear(0);
        press(0);
        ticks(0, 754);
        lit_time("at 12:34", 0, 12, 34);
        @(negedge i_clk);
        #2;
        rst_n = 1'b0;
        #1;
        lit_time("async reset", 0, 0, 0);
        chk("async reset running", int'(run[0]), 0);
        chk("async reset wrap", int'(wr[0]), 0);
        @(negedge i_clk);
        rst_n = 1'b1;
        cyc(2);
        press(0);
        ticks(0, 1);
        lit_time("after reset", 0, 0, 1);

        // four ticks per second
        press(1);
        ticks(1, 7);
        lit_time("tps4 seven", 1, 0, 1);
        chk("tps4 seven presc", int'(presc1), 3);
        press(1);
        clear(1);
        press(1);
        ticks(1, 4);
        lit_time("tps4 restart", 1, 0, 1);
        chk("tps4 restart presc", int'(presc1), 0);
        chk("tps4 running", int'(run[1]), 1);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
